// File: rtl/jeff_mux_scan_capture.sv
// jeff_mux_scan_capture
// Sequences an external quad 2-to-1 nibble mux through its A and B channels,
// captures each settled nibble, and hands the assembled {B,A} byte downstream
// over a valid/ready handshake.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | mux disabled, waiting for run
//  SEL_A | A channel selected, counting the settle window, then latch A
//  SEL_B | B channel selected, counting the settle window, then latch B
//  LOAD  | mux disabled, push {B,A} into the output register when free
module jeff_mux_scan_capture #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  output logic       mux_s,
  output logic       mux_en,
  input  logic [3:0] mux_y,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic [7:0] frame_count,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SEL_A, SEL_B, LOAD} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] a_reg;
  logic [3:0] b_reg;
  logic       settled;
  logic       accept;
  logic       load_ok;

  // The nibble is taken on the last cycle of the settle window.
  assign settled = (cnt == CNT_LAST);
  assign accept  = data_valid && data_ready;
  // The output register is free when empty or being drained on this edge.
  assign load_ok = !data_valid || data_ready;
  assign busy    = (state != IDLE);

  // Scan sequencer, capture registers and output handshake in one process.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      a_reg       <= 4'd0;
      b_reg       <= 4'd0;
      mux_s       <= 1'b0;
      mux_en      <= 1'b1;
      data_out    <= 8'h00;
      data_valid  <= 1'b0;
      frame_count <= 8'h00;
    end else begin
      // A transfer drains the word; a load later in this process may refill it.
      if (accept) begin
        frame_count <= frame_count + 8'd1;
        data_valid  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (run) begin
            state  <= SEL_A;
            cnt    <= 4'd0;
            mux_en <= 1'b0;
            mux_s  <= 1'b0;
          end
        end

        SEL_A: begin
          if (settled) begin
            a_reg <= mux_y;
            cnt   <= 4'd0;
            state <= SEL_B;
            mux_s <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        SEL_B: begin
          if (settled) begin
            b_reg  <= mux_y;
            cnt    <= 4'd0;
            state  <= LOAD;
            mux_en <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        LOAD: begin
          // Stall here under backpressure so the captured pair is never lost.
          if (load_ok) begin
            data_out   <= {b_reg, a_reg};
            data_valid <= 1'b1;
            cnt        <= 4'd0;
            mux_s      <= 1'b0;
            if (run) begin
              state  <= SEL_A;
              mux_en <= 1'b0;
            end else begin
              state  <= IDLE;
              mux_en <= 1'b1;
            end
          end
        end

        default: begin
          state  <= IDLE;
          mux_s  <= 1'b0;
          mux_en <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jeff_mux_scan_capture.sv
// Directed bench for jeff_mux_scan_capture with a behavioural nibble mux.
module tb_jeff_mux_scan_capture;

  localparam int SETTLE   = 2;
  localparam int WORD_CYC = 2 * SETTLE + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       data_ready;
  logic [3:0] mux_y;
  logic       mux_s;
  logic       mux_en;
  logic [7:0] data_out;
  logic       data_valid;
  logic [7:0] frame_count;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Pair index of the word being assembled; it advances whenever the select
  // drops from B back to A (end of a word, or reset abandoning one).
  int   pair_idx = 0;
  logic prev_s   = 1'b0;

  logic [7:0] xfer_q[$];
  int         xfer_t[$];
  int         cyc = 0;

  jeff_mux_scan_capture #(.SETTLE(SETTLE)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .mux_s       (mux_s),
    .mux_en      (mux_en),
    .mux_y       (mux_y),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .frame_count (frame_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] pair_a(input int i);
    case (i)
      0: pair_a = 4'hA;
      1: pair_a = 4'h3;
      2: pair_a = 4'h2;
      3: pair_a = 4'h9;
      4: pair_a = 4'h6;
      5: pair_a = 4'h3;
      6: pair_a = 4'h2;
      7: pair_a = 4'hE;
      8: pair_a = 4'hC;
      default: pair_a = i[3:0];
    endcase
  endfunction

  function automatic logic [3:0] pair_b(input int i);
    case (i)
      0: pair_b = 4'h5;
      1: pair_b = 4'h7;
      2: pair_b = 4'h8;
      3: pair_b = 4'h4;
      4: pair_b = 4'h1;
      5: pair_b = 4'h7;
      6: pair_b = 4'h8;
      7: pair_b = 4'hE;
      8: pair_b = 4'hD;
      default: pair_b = ~i[3:0];
    endcase
  endfunction

  // Behavioural mux: disabled output is zero, otherwise the selected nibble.
  assign mux_y = (mux_en !== 1'b0) ? 4'h0 :
                 (mux_s ? pair_b(pair_idx) : pair_a(pair_idx));

  always @(negedge clk) begin
    if (prev_s === 1'b1 && mux_s === 1'b0) pair_idx = pair_idx + 1;
    prev_s = mux_s;
  end

  // Transfer monitor: values seen at the edge, before the DUT updates.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset === 1'b0 && data_valid === 1'b1 && data_ready === 1'b1) begin
      xfer_q.push_back(data_out);
      xfer_t.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_word(input string tag, input int i, input logic [7:0] exp);
    if (i < xfer_q.size()) check_eq(tag, 32'(xfer_q[i]), 32'(exp));
    else check_eq({tag, "_count"}, xfer_q.size(), i + 1);
  endtask

  task automatic check_idle_reset(input string tag);
    check_eq({tag, "_en"}, 32'(mux_en), 1);
    check_eq({tag, "_s"}, 32'(mux_s), 0);
    check_eq({tag, "_dout"}, 32'(data_out), 0);
    check_eq({tag, "_dv"}, 32'(data_valid), 0);
    check_eq({tag, "_fc"}, 32'(frame_count), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic clear_xfers();
    xfer_q.delete();
    xfer_t.delete();
  endtask

  initial begin
    int lat;
    int hold_bad;
    int busy_low;
    int start_idx;
    bit seen255;
    logic [7:0] exp_w;

    // Reset held two cycles with run high.
    reset = 1'b1;
    run = 1'b1;
    data_ready = 1'b1;
    @(negedge clk);
    check_idle_reset("rst1");
    @(negedge clk);
    check_idle_reset("rst2");
    reset = 1'b0;
    run = 1'b0;
    @(negedge clk);

    // Single word A=A, B=5 with a one-cycle run pulse.
    clear_xfers();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    check_eq("sel_a_en", 32'(mux_en), 0);
    check_eq("sel_a_busy", 32'(busy), 1);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (data_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    check_eq("single_lat", lat, WORD_CYC);
    check_eq("single_dout", 32'(data_out), 32'h5A);
    @(negedge clk);
    check_eq("single_fc", 32'(frame_count), 1);
    check_eq("single_dv_clr", 32'(data_valid), 0);
    check_eq("single_idle_en", 32'(mux_en), 1);
    check_eq("single_idle_busy", 32'(busy), 0);
    check_word("single_w0", 0, 8'h5A);

    // Continuous stream; run dropped mid-scan must still finish that word.
    clear_xfers();
    run = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (xfer_q.size() >= 3) break;
    end
    run = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (xfer_q.size() >= 4 && busy === 1'b0 && data_valid === 1'b0) break;
    end
    check_word("stream_w0", 0, 8'h73);
    check_word("stream_w1", 1, 8'h82);
    check_word("stream_w2", 2, 8'h49);
    check_word("stream_tail", 3, 8'h16);
    if (xfer_t.size() >= 3) begin
      check_eq("stream_gap01", xfer_t[1] - xfer_t[0], WORD_CYC);
      check_eq("stream_gap12", xfer_t[2] - xfer_t[1], WORD_CYC);
    end else begin
      check_eq("stream_gap_count", xfer_t.size(), 3);
    end
    check_eq("stream_fc", 32'(frame_count), 5);
    check_eq("stream_busy", 32'(busy), 0);

    // Backpressure for 20 cycles.
    clear_xfers();
    data_ready = 1'b0;
    run = 1'b1;
    hold_bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (data_valid === 1'b1 && data_out !== 8'h73) hold_bad++;
    end
    check_eq("bp_hold", hold_bad, 0);
    check_eq("bp_dout", 32'(data_out), 32'h73);
    check_eq("bp_dv", 32'(data_valid), 1);
    check_eq("bp_en", 32'(mux_en), 1);
    check_eq("bp_s", 32'(mux_s), 1);
    check_eq("bp_busy", 32'(busy), 1);
    check_eq("bp_fc", 32'(frame_count), 5);
    check_eq("bp_noxfer", xfer_q.size(), 0);
    run = 1'b0;
    data_ready = 1'b1;
    @(negedge clk);
    check_eq("rel_dout", 32'(data_out), 32'h82);
    check_eq("rel_dv", 32'(data_valid), 1);
    check_eq("rel_fc", 32'(frame_count), 6);
    @(negedge clk);
    check_eq("rel_dv_clr", 32'(data_valid), 0);
    check_eq("rel_fc2", 32'(frame_count), 7);
    check_word("rel_w0", 0, 8'h73);
    check_word("rel_w1", 1, 8'h82);

    // Reset during SEL_B discards the partial word.
    clear_xfers();
    run = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mux_s === 1'b1 && mux_en === 1'b0) break;
    end
    check_eq("midrst_in_selb", 32'(mux_s), 1);
    reset = 1'b1;
    run = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_idle_reset("midrst");
    repeat (10) @(negedge clk);
    check_eq("midrst_noxfer", xfer_q.size(), 0);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (xfer_q.size() >= 1) break;
    end
    check_word("fresh_w0", 0, 8'hDC);
    check_eq("fresh_fc", 32'(frame_count), 1);

    // 256 words back to back: counter wraps, busy never drops.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_xfers();
    start_idx = pair_idx;
    run = 1'b1;
    busy_low = 0;
    seen255 = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 1400; k++) begin
      if (busy !== 1'b1) busy_low++;
      if (xfer_q.size() >= 255 && !seen255) begin
        seen255 = 1'b1;
        check_eq("wrap_fc_ff", 32'(frame_count), 32'hFF);
      end
      if (xfer_q.size() >= 256) break;
      @(negedge clk);
    end
    check_eq("wrap_fc_00", 32'(frame_count), 0);
    check_eq("wrap_busy_low", busy_low, 0);
    exp_w = {pair_b(start_idx), pair_a(start_idx)};
    check_word("wrap_first", 0, exp_w);
    exp_w = {pair_b(start_idx + 255), pair_a(start_idx + 255)};
    check_word("wrap_last", 255, exp_w);
    run = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy === 1'b0 && data_valid === 1'b0) break;
    end
    check_eq("wrap_end_busy", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
